// File: rtl/qdec_pkg.sv
// Shared encodings for the quadrature decoder: resolution modes, gray states, direction.
package qdec_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  // Gray states as {A,B}
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S01 = 2'b01;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic logic is_fwd(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == S00) && (cur == S10)) || ((prev == S10) && (cur == S11)) ||
           ((prev == S11) && (cur == S01)) || ((prev == S01) && (cur == S00)) ?
           DIR_FWD : DIR_REV;
  endfunction

endpackage

// File: rtl/qdec_filter.sv
// Pin synchroniser plus run-length glitch filter; level/valid lag the pin by SYNC_STAGES+FILTER_LEN edges.
// No backpressure: samples every cycle.
module qdec_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic valid
);

  localparam int RW = $clog2(FILTER_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] real_q;
  logic                   cand;
  logic [RW-1:0]          run;
  logic [RW-1:0]          run_nxt;
  logic                   smp;
  logic                   smp_real;

  assign smp      = sync_q[SYNC_STAGES-1];
  // Reset contents of the synchroniser are not pin samples and must not be filtered
  assign smp_real = real_q[SYNC_STAGES-1];

  always_comb begin
    run_nxt = RW'(1);
    if (smp == cand) begin
      run_nxt = (run == RUN_MAX) ? run : run + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      real_q <= '0;
      cand   <= 1'b0;
      run    <= '0;
      level  <= 1'b0;
      valid  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      real_q <= {real_q[SYNC_STAGES-2:0], 1'b1};
      if (smp_real) begin
        cand <= smp;
        run  <= run_nxt;
        if (run_nxt == RUN_MAX) begin
          level <= smp;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/qdec_counter.sv
// Quadrature decoder with bounded up/down counter; pin change reaches data after SYNC_STAGES+FILTER_LEN+1 edges.
// No backpressure; optional index input/pulse when INDEX_EN is defined.
module qdec_counter #(
  parameter int WIDTH       = 14,
  parameter int MAX_COUNT   = 9999,
  parameter int STEP        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ina,
  input  logic             inb,
  input  logic [1:0]       mode,
  input  logic             wrap_en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data,
  output logic             dir,
  output logic             step,
  output logic             ovf,
  output logic             unf,
  output logic             err
`ifdef INDEX_EN
  ,
  input  logic             inz,
  output logic             idx
`endif
);

  import qdec_pkg::*;

  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_W  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX_COUNT);

  logic a_lvl, a_vld, b_lvl, b_vld;

  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .pin(ina), .level(a_lvl), .valid(a_vld)
  );

  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .pin(inb), .level(b_lvl), .valid(b_vld)
  );

  logic       init;
  logic [1:0] prev_ab;
  logic [1:0] cur_ab;
  logic       both_chg;
  logic       legal;
  logic       fwd;
  logic       cnt_ev;
  logic       z_rise;

  assign cur_ab = {a_lvl, b_lvl};

  always_comb begin
    both_chg = init && (cur_ab[1] != prev_ab[1]) && (cur_ab[0] != prev_ab[0]);
    legal    = init && (cur_ab != prev_ab) && !both_chg;
    fwd      = is_fwd(prev_ab, cur_ab);
    case (mode)
      MODE_X1: cnt_ev = legal && !prev_ab[0] && cur_ab[0];
      MODE_X2: cnt_ev = legal && (prev_ab[0] != cur_ab[0]);
      default: cnt_ev = legal;
    endcase
  end

  // All bound arithmetic at WIDTH+1 bits so MAX_COUNT+STEP cannot overflow
  logic [WIDTH:0]   cnt_w;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   inc_wrap;
  logic [WIDTH:0]   dec_sub;
  logic [WIDTH:0]   dec_wrap;
  logic [WIDTH-1:0] load_cl;

  assign cnt_w    = {1'b0, data};
  assign inc_sum  = cnt_w + STEP_W;
  assign inc_wrap = inc_sum - (MAX_W + ONE_W);
  assign dec_sub  = cnt_w - STEP_W;
  assign dec_wrap = cnt_w + MAX_W + ONE_W - STEP_W;
  assign load_cl  = ({1'b0, load_val} > MAX_W) ? MAX_N : load_val;

`ifdef INDEX_EN
  logic z_lvl, z_vld, z_prev;

  qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(clk), .rst(rst), .pin(inz), .level(z_lvl), .valid(z_vld)
  );

  assign z_rise = z_vld && z_lvl && !z_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_prev <= 1'b0;
      idx    <= 1'b0;
    end else begin
      z_prev <= z_lvl;
      idx    <= z_rise;
    end
  end
`else
  assign z_rise = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init    <= 1'b0;
      prev_ab <= S00;
      data    <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      step <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      err  <= both_chg;
      // First valid sample only seeds the state, so pins high at power-up never count
      if (!init) begin
        if (a_vld && b_vld) begin
          init    <= 1'b1;
          prev_ab <= cur_ab;
        end
      end else begin
        prev_ab <= cur_ab;
      end

      if (clr) begin
        data <= '0;
      end else if (z_rise) begin
        data <= '0;
      end else if (load) begin
        data <= load_cl;
      end else if (cnt_ev) begin
        step <= 1'b1;
        dir  <= fwd;
        if (fwd) begin
          if (inc_sum <= MAX_W) begin
            data <= WIDTH'(inc_sum);
          end else begin
            ovf  <= 1'b1;
            data <= wrap_en ? WIDTH'(inc_wrap) : MAX_N;
          end
        end else begin
          if (cnt_w >= STEP_W) begin
            data <= WIDTH'(dec_sub);
          end else begin
            unf  <= 1'b1;
            data <= wrap_en ? WIDTH'(dec_wrap) : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qdec_counter.sv
// Directed bench for qdec_counter: default instance plus a STEP=3/MAX_COUNT=10 instance on shared inputs.
module tb_qdec_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ina, inb;
  logic [1:0]  mode;
  logic        wrap_en, clr, load;
  logic [13:0] load_val;
  logic [13:0] data, data3;
  logic        dir, step, ovf, unf, err;
  logic        dir3, step3, ovf3, unf3, err3;
`ifdef INDEX_EN
  logic        inz, idx, idx3;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int st_cnt, ov_cnt, un_cnt, er_cnt, st3_cnt, ov3_cnt, ix_cnt;

  logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  always #5 clk = ~clk;

  qdec_counter dut (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .mode(mode), .wrap_en(wrap_en),
    .clr(clr), .load(load), .load_val(load_val), .data(data), .dir(dir),
    .step(step), .ovf(ovf), .unf(unf), .err(err)
`ifdef INDEX_EN
    , .inz(inz), .idx(idx)
`endif
  );

  qdec_counter #(.MAX_COUNT(10), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .mode(mode), .wrap_en(wrap_en),
    .clr(clr), .load(load), .load_val(load_val), .data(data3), .dir(dir3),
    .step(step3), .ovf(ovf3), .unf(unf3), .err(err3)
`ifdef INDEX_EN
    , .inz(inz), .idx(idx3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_acc();
    st_cnt = 0; ov_cnt = 0; un_cnt = 0; er_cnt = 0; st3_cnt = 0; ov3_cnt = 0; ix_cnt = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      st_cnt  += int'(step);
      ov_cnt  += int'(ovf);
      un_cnt  += int'(unf);
      er_cnt  += int'(err);
      st3_cnt += int'(step3);
      ov3_cnt += int'(ovf3);
`ifdef INDEX_EN
      ix_cnt  += int'(idx);
`endif
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
  endtask

  task automatic pulse_load(input logic [13:0] v);
    load_val = v; load = 1'b1; tick(1); load = 1'b0; tick(1);
  endtask

  initial begin
    rst = 1'b1; ina = 1'b0; inb = 1'b0; mode = 2'd2; wrap_en = 1'b1;
    clr = 1'b0; load = 1'b0; load_val = '0;
`ifdef INDEX_EN
    inz = 1'b0;
`endif
    clr_acc();
    tick(3);
    check("rst_data", 32'(data), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_step", 32'(step), 0);
    check("rst_ovf_unf_err", 32'({ovf, unf, err}), 0);
    rst = 1'b0;
    tick(10);

    // Four forward cycles in x4, first edge timed for latency
    clr_acc();
    for (int i = 0; i < 16; i++) begin
      {ina, inb} = fwd_seq[i % 4];
      if (i == 0) begin
        tick(5);
        check("lat_before", 32'(data), 0);
        tick(1);
        check("lat_data", 32'(data), 1);
        check("lat_step", 32'(step), 1);
        tick(14);
      end else begin
        tick(20);
      end
    end
    check("x4_data", 32'(data), 16);
    check("x4_dir", 32'(dir), 1);
    check("x4_steps", 32'(st_cnt), 16);
    check("x4_ovf", 32'(ov_cnt), 0);
    check("x4_data3", 32'(data3), 4);
    check("x4_ovf3", 32'(ov3_cnt), 4);

    // Reverse cycle in x1, wrap then saturate
    pulse_clr();
    check("clr_data", 32'(data), 0);
    mode = 2'd0;
    clr_acc();
    for (int i = 0; i < 4; i++) begin
      {ina, inb} = rev_seq[i];
      tick(20);
    end
    check("x1w_data", 32'(data), 9999);
    check("x1w_unf", 32'(un_cnt), 1);
    check("x1w_steps", 32'(st_cnt), 1);
    check("x1w_dir", 32'(dir), 0);
    check("x1w_data3", 32'(data3), 8);
    wrap_en = 1'b0;
    pulse_clr();
    clr_acc();
    for (int i = 0; i < 4; i++) begin
      {ina, inb} = rev_seq[i];
      tick(20);
    end
    check("x1s_data", 32'(data), 0);
    check("x1s_unf", 32'(un_cnt), 1);
    check("x1s_steps", 32'(st_cnt), 1);

    // Overflow with STEP=3, MAX_COUNT=10
    mode = 2'd2; wrap_en = 1'b1;
    pulse_load(14'd9);
    check("load_data", 32'(data), 9);
    clr_acc();
    {ina, inb} = 2'b10; tick(20);
    check("ovw_data", 32'(data), 10);
    check("ovw_ovf", 32'(ov_cnt), 0);
    check("ovw_data3", 32'(data3), 1);
    check("ovw_ovf3", 32'(ov3_cnt), 1);
    wrap_en = 1'b0;
    pulse_load(14'd9);
    clr_acc();
    {ina, inb} = 2'b11; tick(20);
    check("ovs_data3", 32'(data3), 10);
    check("ovs_ovf3", 32'(ov3_cnt), 1);
    clr_acc();
    {ina, inb} = 2'b01; tick(20);
    check("sat_data3", 32'(data3), 10);
    check("sat_ovf3", 32'(ov3_cnt), 1);
    check("sat_step3", 32'(st3_cnt), 1);
    check("sat_data", 32'(data), 11);
    pulse_load(14'd12000);
    check("ldclamp_data", 32'(data), 9999);
    check("ldclamp_data3", 32'(data3), 10);
    clr_acc();
    {ina, inb} = 2'b00; tick(20);
    check("max_data", 32'(data), 9999);
    check("max_ovf", 32'(ov_cnt), 1);
    check("max_step", 32'(st_cnt), 1);

    // Glitch shorter than the filter, then an illegal double change
    clr_acc();
    ina = 1'b1; tick(2); ina = 1'b0; tick(15);
    check("glitch_steps", 32'(st_cnt), 0);
    check("glitch_data", 32'(data), 9999);
    check("glitch_err", 32'(er_cnt), 0);
    {ina, inb} = 2'b11; tick(15);
    check("illegal_err", 32'(er_cnt), 1);
    check("illegal_data", 32'(data), 9999);
    check("illegal_steps", 32'(st_cnt), 0);

    // Pins high through reset release
    rst = 1'b1; tick(3);
    check("rst2_data", 32'(data), 0);
    rst = 1'b0;
    clr_acc();
    tick(20);
    check("init_data", 32'(data), 0);
    check("init_steps", 32'(st_cnt), 0);
    check("init_err", 32'(er_cnt), 0);
    ina = 1'b0; tick(20);
    check("init_edge_data", 32'(data), 1);
    check("init_edge_steps", 32'(st_cnt), 1);
    check("init_edge_dir", 32'(dir), 1);
    check("init_edge_data3", 32'(data3), 3);

    // clr coinciding with the counted edge
    clr_acc();
    inb = 1'b0;
    tick(5);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("clrcol_data", 32'(data), 0);
    check("clrcol_step", 32'(step), 0);
    tick(10);
    check("clrcol_after", 32'(data), 0);
    check("clrcol_steps", 32'(st_cnt), 0);
    check("clrcol_dir", 32'(dir), 1);

`ifdef INDEX_EN
    pulse_load(14'd57);
    check("idx_pre", 32'(data), 57);
    clr_acc();
    inz = 1'b1; tick(15); inz = 1'b0; tick(10);
    check("idx_data", 32'(data), 0);
    check("idx_pulses", 32'(ix_cnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qdec_counter.md
Name: qdec_counter

Overview:
- Parametrised quadrature-encoder decoder and bounded up/down counter. It is the successor to the lab FSM encoder counter.
- Adds input synchronisation and a glitch filter, selectable x1/x2/x4 resolution, a configurable step and modulus, a wrap/saturate option, clear/load, and illegal-transition detection.
- Drives the display/BCD path with a 0..MAX_COUNT value.

Parameters:
- WIDTH, 14: counter/data width. Requires MAX_COUNT < 2**WIDTH.
- MAX_COUNT, 9999: upper bound of the count range 0..MAX_COUNT.
- STEP, 1: amount added/subtracted per counted edge. Requires 1 <= STEP <= MAX_COUNT.
- SYNC_STAGES, 2: flip-flop synchroniser depth per encoder pin (>=2).
- FILTER_LEN, 3: consecutive identical synchronised samples required before a pin level is accepted (>=1).

Ports:
- clk  in  1  system clock (1 kHz..50 MHz); all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- ina  in  1  encoder channel A, asynchronous.
- inb  in  1  encoder channel B, asynchronous, 90 deg from A.
- mode  in  2  resolution: 0 = x1, 1 = x2, 2 = x4, 3 = reserved (treated as x4).
- wrap_en  in  1  1 = modular wrap at the bounds, 0 = saturate.
- clr  in  1  synchronous clear of the count.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load; values > MAX_COUNT are clamped to MAX_COUNT.
- data  out  WIDTH  current count.
- dir  out  1  direction of the last counted step: 1 = forward (A leads B).
- step  out  1  one-cycle pulse on every counted edge.
- ovf  out  1  one-cycle pulse when an increment crosses MAX_COUNT (wrapped or clamped).
- unf  out  1  one-cycle pulse when a decrement crosses 0 (wrapped or clamped).
- err  out  1  one-cycle pulse on an illegal transition (both filtered pins change in the same cycle).

Behaviour:
- Reset (async assert, sync release): data = 0; dir, step, ovf, unf, err = 0; synchronisers, filters and decoder state = 0; init flag cleared.
- Filter: the accepted level changes only after FILTER_LEN consecutive equal synchronised samples that differ from the current accepted level. Shorter pulses are ignored.
- Init: the first cycle after reset in which both filters have produced a valid accepted level loads the decoder state {A,B} with no count.
  - This prevents a spurious count when the pins are high at power-up.
- Decoder: compare the previous and current accepted {A,B}.
  - Forward sequence: 00 -> 10 -> 11 -> 01 -> 00.
  - Reverse sequence: the same in the opposite order.
  - No change: nothing happens.
  - Both bits changed: err pulses, no count, the state is updated to the new value.
- Counted edges by mode:
  - x4: every legal transition.
  - x2: transitions where B changes.
  - x1: B rising only. Forward if A = 1, reverse if A = 0.
- Increment by STEP:
  - If cnt + STEP <= MAX_COUNT: cnt += STEP.
  - Otherwise, wrap_en = 1: cnt = cnt + STEP - (MAX_COUNT + 1); wrap_en = 0: cnt = MAX_COUNT.
  - ovf pulses in both boundary cases.
  - Arithmetic is done at WIDTH+1 bits.
- Decrement by STEP:
  - If cnt >= STEP: cnt -= STEP.
  - Otherwise, wrap_en = 1: cnt = cnt + MAX_COUNT + 1 - STEP; wrap_en = 0: cnt = 0.
  - unf pulses in both boundary cases.
- Saturated boundary with no movement (e.g. increment at MAX_COUNT, wrap_en = 0): data is unchanged; step and ovf/unf still pulse.
- Priority: clr > load > count.
  - A count event in the same cycle as clr or load is dropped; step, ovf and unf stay 0; dir is unchanged; err still reports.
- Latency: a pin level change, held stable, appears on data SYNC_STAGES + FILTER_LEN + 1 rising edges after the first edge that samples it.
  - With defaults: 6 edges.
  - step, dir, ovf and unf are registered together with data.
- Mode or wrap_en change: takes effect on the next counted edge. The decoder state is not reset.
- Reset mid-transition: all state is discarded; the init rule applies again after release.

Optional Feature:
- INDEX_EN defined:
  - Adds port inz (in, 1), the encoder index pulse, passed through its own synchroniser and filter.
  - The rising edge of the accepted inz sets data to 0 in that cycle, ranked between clr and load.
  - Also adds output idx (out, 1), a one-cycle pulse on that event.
- INDEX_EN undefined: no inz/idx ports and no index logic.

Decomposition:
- Package qdec_pkg holds:
  - mode encodings MODE_X1/MODE_X2/MODE_X4;
  - 2-bit gray state constants S00/S10/S11/S01;
  - the direction constants.
- Sub-module qdec_filter (synchroniser + FILTER_LEN glitch filter + valid flag), parametrised by SYNC_STAGES and FILTER_LEN.
  - Instantiated once per pin (three instances with INDEX_EN).
- Decoder and counter stay in qdec_counter.

Test Plan:
- Four forward quadrature cycles, mode x4, defaults, 20 clk per phase -> data = 16, dir = 1, 16 step pulses; first update 6 edges after the first pin change.
- From data = 0, one reverse cycle in x1 with wrap_en = 1 -> data = 9999, unf pulses once; repeat with wrap_en = 0 -> data stays 0, unf pulses.
- STEP = 3, MAX_COUNT = 10, load_val = 9, one forward x4 edge -> data = 1 with wrap_en = 1, 10 with wrap_en = 0; ovf pulses in both.
- 2-cycle glitch on ina (FILTER_LEN = 3) -> no step, data unchanged; both pins toggled in the same cycle -> err pulse, data unchanged.
- Pins held at 11 through reset release, then a forward edge to 01 -> no count at init, exactly one count (+1) after the edge.
- clr and a count edge in the same cycle -> data = 0, step = 0; with INDEX_EN, an inz pulse at data = 57 -> data = 0 and idx pulses.
